// File: rtl/retire_trace_sink_pkg.sv
// ---------------------------------------------------------------------------
// retire_trace_sink_pkg
// Shared types and constants for the retire-trace sink.
//
// Contents:
//   TRACE_XLEN          datapath width of pc / instr / data fields in a record
//   TRACE_SEQ_W         width of the sequence tag and the retire counter
//   TRACE_DEPTH_DEFAULT default number of buffered trace records
//   retire_rec_t        one captured retire event
//
// Configuration macro: RETIRE_TRACE_MEM_EN
//   defined   -> records carry has_mem / mem_addr / mem_data
//   undefined -> store information is omitted and the record narrows
// ---------------------------------------------------------------------------
package retire_trace_sink_pkg;

    localparam int TRACE_XLEN          = 32;
    localparam int TRACE_SEQ_W         = 32;
    localparam int TRACE_DEPTH_DEFAULT = 16;

    // Field order puts the sequence tag in the most significant bits so a raw
    // hex dump of a record starts with its sequence number.
    typedef struct packed {
        logic [TRACE_SEQ_W-1:0] seq;
        logic [TRACE_XLEN-1:0]  pc;
        logic [31:0]            instr;
        logic                   has_rd;
        logic [4:0]             rd_addr;
        logic [TRACE_XLEN-1:0]  rd_data;
`ifdef RETIRE_TRACE_MEM_EN
        logic                   has_mem;
        logic [TRACE_XLEN-1:0]  mem_addr;
        logic [TRACE_XLEN-1:0]  mem_data;
`endif
    } retire_rec_t;

endpackage

// File: rtl/retire_trace_sink_if.sv
// ---------------------------------------------------------------------------
// retire_trace_sink_if
// Bundles the retire-trace input port, the record drain handshake and the
// statistics outputs of retire_trace_sink.
//
// Parameters:
//   DEPTH   FIFO entries (sets the width of count_o)
//   DROP_W  width of the saturating drop counter
//
// Modports:
//   master  core/consumer side: drives the retire fields, clr_i, rec_ready_i
//   slave   the sink itself
// ---------------------------------------------------------------------------
interface retire_trace_sink_if #(
    parameter int DEPTH  = retire_trace_sink_pkg::TRACE_DEPTH_DEFAULT,
    parameter int DROP_W = 16
);
    localparam int XLEN  = retire_trace_sink_pkg::TRACE_XLEN;
    localparam int SEQ_W = retire_trace_sink_pkg::TRACE_SEQ_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                               update_i;
    logic [XLEN-1:0]                    pc_i;
    logic [31:0]                        instr_i;
    logic [4:0]                         reg_addr_i;
    logic [XLEN-1:0]                    reg_data_i;
    logic [XLEN-1:0]                    mem_addr_i;
    logic [XLEN-1:0]                    mem_data_i;
    logic                               clr_i;
    logic                               rec_valid_o;
    logic                               rec_ready_i;
    retire_trace_sink_pkg::retire_rec_t rec_o;
    logic [CNT_W-1:0]                   count_o;
    logic                               overflow_o;
    logic [DROP_W-1:0]                  drop_cnt_o;
    logic [SEQ_W-1:0]                   retire_cnt_o;

    modport master (
        output update_i, pc_i, instr_i, reg_addr_i, reg_data_i,
               mem_addr_i, mem_data_i, clr_i, rec_ready_i,
        input  rec_valid_o, rec_o, count_o, overflow_o, drop_cnt_o,
               retire_cnt_o
    );

    modport slave (
        input  update_i, pc_i, instr_i, reg_addr_i, reg_data_i,
               mem_addr_i, mem_data_i, clr_i, rec_ready_i,
        output rec_valid_o, rec_o, count_o, overflow_o, drop_cnt_o,
               retire_cnt_o
    );

endinterface

// File: rtl/retire_trace_sink_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo_fwft
// Single-clock first-word-fall-through FIFO: the head entry is visible on
// dout whenever count > 0, and reads zero when the FIFO is empty.
//
// Parameters:
//   WIDTH  entry width in bits
//   DEPTH  number of entries; power of two, >= 2
//
// Ports:
//   clk    clock
//   rst    asynchronous active-high reset (empties the FIFO)
//   clr    synchronous clear, overrides push and pop
//   push   write din at the tail (caller guarantees room)
//   pop    drop the head entry (caller guarantees count > 0)
//   din    tail data
//   dout   head data
//   count  occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;

    // Storage has no reset; stale entries are never visible because the
    // output is gated by the occupancy count.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            storage[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two. The count is
    // kept explicitly so that full (DEPTH) and empty (0) are unambiguous.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout  = (count_q != '0) ? storage[rd_ptr] : '0;
    assign count = count_q;

endmodule

// File: rtl/retire_trace_sink.sv
// ---------------------------------------------------------------------------
// retire_trace_sink
// Consumer end of the core's retire-trace port. Every retire strobe is packed
// into a tagged record (seq = retire count before the event) and buffered in
// a FWFT FIFO drained over a valid/ready port. Events that find the FIFO full
// are dropped and counted; gaps in seq expose them to the log reader.
//
// Parameters:
//   DEPTH   FIFO entries; power of two, >= 2
//   DROP_W  width of the saturating drop counter
//   (XLEN and SEQ_W are fixed by retire_trace_sink_pkg, which owns the record)
//
// Ports:
//   clk_i   system clock
//   rst_i   asynchronous active-high reset
//   bus     retire_trace_sink_if.slave:
//             update_i, pc_i, instr_i, reg_addr_i, reg_data_i,
//             mem_addr_i, mem_data_i, clr_i, rec_ready_i   (inputs)
//             rec_valid_o, rec_o, count_o, overflow_o,
//             drop_cnt_o, retire_cnt_o                      (outputs)
//
// Configuration macro: RETIRE_TRACE_MEM_EN (store fields in the record)
// ---------------------------------------------------------------------------
module retire_trace_sink
    import retire_trace_sink_pkg::*;
#(
    parameter int DEPTH  = TRACE_DEPTH_DEFAULT,
    parameter int DROP_W = 16
) (
    input logic                clk_i,
    input logic                rst_i,
    retire_trace_sink_if.slave bus
);
    localparam int                CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam int                REC_W    = $bits(retire_rec_t);

    retire_rec_t             rec_next;
    logic [REC_W-1:0]        fifo_head;
    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_valid;
    logic                    pop;
    logic                    room;
    logic                    push;
    logic                    drop;
    logic [TRACE_SEQ_W-1:0]  retire_cnt;
    logic [DROP_W-1:0]       drop_cnt;
    logic                    overflow;

    // Record packing. Register x0 writes are normalised to has_rd=0 with zero
    // data so that the log never shows a phantom write to x0.
    always_comb begin
        rec_next         = '0;
        rec_next.seq     = retire_cnt;
        rec_next.pc      = bus.pc_i;
        rec_next.instr   = bus.instr_i;
        rec_next.has_rd  = (bus.reg_addr_i != 5'd0);
        rec_next.rd_addr = bus.reg_addr_i;
        rec_next.rd_data = rec_next.has_rd ? bus.reg_data_i : '0;
`ifdef RETIRE_TRACE_MEM_EN
        // A store of zero to address zero looks identical to "no store".
        rec_next.has_mem  = (bus.mem_addr_i != '0) || (bus.mem_data_i != '0);
        rec_next.mem_addr = bus.mem_addr_i;
        rec_next.mem_data = bus.mem_data_i;
`endif
    end

`ifndef RETIRE_TRACE_MEM_EN
    logic unused_mem_fields;
    assign unused_mem_fields = ^{bus.mem_addr_i, bus.mem_data_i};
`endif

    // Push/drop decision. A full FIFO still takes a new record when the head
    // leaves in the same cycle. clr discards both the pop and the event.
    assign fifo_valid = (fifo_count != '0);
    assign pop        = fifo_valid && bus.rec_ready_i && !bus.clr_i;
    assign room       = (fifo_count != FULL_CNT) || pop;
    assign push       = bus.update_i && !bus.clr_i && room;
    assign drop       = bus.update_i && !bus.clr_i && !room;

    sync_fifo_fwft #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (bus.clr_i),
        .push  (push),
        .pop   (pop),
        .din   (rec_next),
        .dout  (fifo_head),
        .count (fifo_count)
    );

    // Statistics. The retire counter counts every event, dropped or not, so
    // that it always matches the next sequence tag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            retire_cnt <= '0;
            drop_cnt   <= '0;
            overflow   <= 1'b0;
        end else if (bus.clr_i) begin
            retire_cnt <= '0;
            drop_cnt   <= '0;
            overflow   <= 1'b0;
        end else begin
            if (bus.update_i) begin
                retire_cnt <= retire_cnt + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != {DROP_W{1'b1}}) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.rec_valid_o  = fifo_valid;
    assign bus.rec_o        = retire_rec_t'(fifo_head);
    assign bus.count_o      = fifo_count;
    assign bus.overflow_o   = overflow;
    assign bus.drop_cnt_o   = drop_cnt;
    assign bus.retire_cnt_o = retire_cnt;

endmodule

// File: tb/tb_retire_trace_sink.sv
// ---------------------------------------------------------------------------
// tb_retire_trace_sink
// Self-checking bench for retire_trace_sink. The stimulus process keeps a
// queue-based reference of the trace buffer and its statistics; a separate
// monitor pops expected records from that queue on every DUT handshake.
// DROP_W is kept small here so that saturation of the drop counter is reached.
// ---------------------------------------------------------------------------
module tb_retire_trace_sink;
    import retire_trace_sink_pkg::*;

    localparam int DEPTH    = 16;
    localparam int DROP_W   = 3;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    retire_trace_sink_if #(.DEPTH(DEPTH), .DROP_W(DROP_W)) bus ();

    retire_trace_sink #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference state: expected buffer contents and statistics.
    retire_rec_t            exp_q [$];
    int                     m_count  = 0;
    logic [TRACE_SEQ_W-1:0] m_retire = '0;
    int                     m_drop   = 0;
    bit                     m_over   = 1'b0;

    // Monitor state.
    bit          hold_prev = 1'b0;
    retire_rec_t hold_rec;
    retire_rec_t exp_rec;

    task automatic check_eq(input string name, input logic [255:0] act,
                            input logic [255:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Builds the record a retire event should produce, from the field rules.
    function automatic retire_rec_t make_record(
        input logic [TRACE_SEQ_W-1:0] seq, input logic [31:0] pc,
        input logic [31:0] instr, input logic [4:0] ra, input logic [31:0] rd,
        input logic [31:0] ma, input logic [31:0] md);
        retire_rec_t r;
        r       = '0;
        r.seq   = seq;
        r.pc    = pc;
        r.instr = instr;
        if (ra != 5'd0) begin
            r.has_rd  = 1'b1;
            r.rd_addr = ra;
            r.rd_data = rd;
        end
`ifdef RETIRE_TRACE_MEM_EN
        if (ma != 32'd0 || md != 32'd0) begin
            r.has_mem  = 1'b1;
            r.mem_addr = ma;
            r.mem_data = md;
        end
`else
        if (ma == md) r.pc = pc;
`endif
        return r;
    endfunction

    task automatic checkOutput();
        check_eq("count",    256'(bus.count_o),      256'(m_count));
        check_eq("valid",    256'(bus.rec_valid_o),  256'(m_count != 0));
        check_eq("overflow", 256'(bus.overflow_o),   256'(m_over));
        check_eq("drop_cnt", 256'(bus.drop_cnt_o),   256'(m_drop));
        check_eq("retire",   256'(bus.retire_cnt_o), 256'(m_retire));
    endtask

    // One clock cycle: drive inputs, advance the reference, wait for the
    // edge, then compare the statistics outputs.
    task automatic applyStimulus(input bit upd, input bit rdy, input bit clr,
        input logic [31:0] pc, input logic [31:0] instr, input logic [4:0] ra,
        input logic [31:0] rd, input logic [31:0] ma, input logic [31:0] md);
        bit pop;
        bus.update_i    = upd;
        bus.rec_ready_i = clr ? 1'b0 : rdy;
        bus.clr_i       = clr;
        bus.pc_i        = pc;
        bus.instr_i     = instr;
        bus.reg_addr_i  = ra;
        bus.reg_data_i  = rd;
        bus.mem_addr_i  = ma;
        bus.mem_data_i  = md;
        if (clr) begin
            exp_q.delete();
            m_count  = 0;
            m_retire = '0;
            m_drop   = 0;
            m_over   = 1'b0;
        end else begin
            pop = (m_count > 0) && rdy;
            if (upd) begin
                if (m_count < DEPTH || pop) begin
                    exp_q.push_back(make_record(m_retire, pc, instr, ra, rd, ma, md));
                    m_count++;
                end else begin
                    m_over = 1'b1;
                    if (m_drop < DROP_MAX) m_drop++;
                end
                m_retire++;
            end
            if (pop) m_count--;
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic rand_step(input bit upd, input bit rdy, input bit clr);
        logic [4:0]  ra;
        logic [31:0] ma;
        logic [31:0] md;
        ra = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        ma = '0;
        md = '0;
        if ($urandom_range(0, 1) == 1) begin
            ma = $urandom;
            md = $urandom;
        end
        applyStimulus(upd, rdy, clr, $urandom, $urandom, ra, $urandom, ma, md);
    endtask

    task automatic drain_all();
        for (int i = 0; i < 100 && m_count > 0; i++) begin
            rand_step(1'b0, 1'b1, 1'b0);
        end
        check_eq("drained", 256'(exp_q.size()), 256'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"},    256'(bus.rec_valid_o),  256'(0));
        check_eq({tag, "_rec"},      256'(bus.rec_o),        256'(0));
        check_eq({tag, "_count"},    256'(bus.count_o),      256'(0));
        check_eq({tag, "_overflow"}, 256'(bus.overflow_o),   256'(0));
        check_eq({tag, "_drop"},     256'(bus.drop_cnt_o),   256'(0));
        check_eq({tag, "_retire"},   256'(bus.retire_cnt_o), 256'(0));
    endtask

    // Scoreboard monitor: looks at the port half a cycle before each edge.
    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else if (bus.rec_valid_o) begin
            if (hold_prev) check_eq("hold", 256'(bus.rec_o), 256'(hold_rec));
            if (bus.rec_ready_i) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_record: got %0h expected none", bus.rec_o);
                end else begin
                    exp_rec = exp_q.pop_front();
                    check_eq("record", 256'(bus.rec_o), 256'(exp_rec));
                end
                hold_prev = 1'b0;
            end else begin
                hold_prev = 1'b1;
                hold_rec  = bus.rec_o;
            end
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.update_i    = 1'b0;
        bus.rec_ready_i = 1'b0;
        bus.clr_i       = 1'b0;
        bus.pc_i        = '0;
        bus.instr_i     = '0;
        bus.reg_addr_i  = '0;
        bus.reg_data_i  = '0;
        bus.mem_addr_i  = '0;
        bus.mem_data_i  = '0;

        #2;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput();

        $display("[TB] basic order");
        applyStimulus(1, 1, 0, 32'h0, $urandom, 5'd1, $urandom, 0, 0);
        applyStimulus(1, 1, 0, 32'h4, $urandom, 5'd2, $urandom, 0, 0);
        applyStimulus(1, 1, 0, 32'h8, $urandom, 5'd3, $urandom, 0, 0);
        for (int i = 0; i < 3; i++) rand_step(0, 1, 0);

        $display("[TB] x0 normalisation");
        applyStimulus(1, 1, 0, 32'h100, 32'h13, 5'd0, 32'hDEADBEEF, 0, 0);
        applyStimulus(1, 1, 0, 32'h104, 32'h13, 5'd5, 32'h12, 32'h40, 32'h0);
        drain_all();

        $display("[TB] overflow and drop saturation");
        rand_step(0, 0, 1);
        for (int i = 0; i < 20; i++) rand_step(1, 0, 0);
        for (int i = 0; i < 6; i++) rand_step(1, 0, 0);
        drain_all();

        $display("[TB] full with concurrent pop");
        rand_step(0, 0, 1);
        for (int i = 0; i < 16; i++) rand_step(1, 0, 0);
        rand_step(1, 1, 0);
        drain_all();

        $display("[TB] backpressure");
        for (int i = 0; i < 5; i++) rand_step(1, 0, 0);
        rand_step(0, 1, 0);
        rand_step(0, 0, 0);
        rand_step(0, 0, 0);
        rand_step(0, 1, 0);
        rand_step(0, 0, 0);
        rand_step(0, 1, 0);
        drain_all();

        $display("[TB] clear with update");
        for (int i = 0; i < 6; i++) rand_step(1, 0, 0);
        rand_step(1, 1, 1);
        rand_step(0, 0, 0);

        $display("[TB] reset mid-drain");
        for (int i = 0; i < 6; i++) rand_step(1, 0, 0);
        rand_step(0, 1, 0);
        bus.update_i    = 1'b0;
        bus.rec_ready_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        m_count  = 0;
        m_retire = '0;
        m_drop   = 0;
        m_over   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rand_step(0, 0, 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            rand_step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 45,
                      $urandom_range(0, 99) < 2);
        end
        drain_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/retire_trace_sink.md
Name: retire_trace_sink

Overview:
- Consumer end of the core's retire-trace port: pc, instr, reg_addr/reg_data, mem_addr/mem_data and the update strobe.
- Captures each retire event into a tagged record and buffers it in a first-word-fall-through FIFO.
- Drains records over a valid/ready port to a logger or UART bridge.
- Keeps retire and drop statistics so testbenches and debug hardware can detect lost trace.

Parameters:
- XLEN, 32, datapath width of pc/instr/data fields
- DEPTH, 16, FIFO entries; power of two, ≥2
- SEQ_W, 32, width of the sequence tag and retire counter
- DROP_W, 16, width of the saturating drop counter

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; asynchronous, active-high
- update_i  in  1  retire strobe; high at a rising edge = one retire event
- pc_i  in  XLEN  retired PC
- instr_i  in  32  retired instruction
- reg_addr_i  in  5  retired rd (0 = no write)
- reg_data_i  in  XLEN  retired rd data
- mem_addr_i  in  XLEN  retired store address (0 when no store)
- mem_data_i  in  XLEN  retired store data (0 when no store)
- clr_i  in  1  synchronous clear of FIFO, counters and flags
- rec_valid_o  out  1  head record valid
- rec_ready_i  in  1  consumer accepts head record
- rec_o  out  $bits(retire_rec_t)  head record
- count_o  out  $clog2(DEPTH)+1  occupancy
- overflow_o  out  1  sticky: at least one record dropped
- drop_cnt_o  out  DROP_W  dropped records, saturating
- retire_cnt_o  out  SEQ_W  total retire events seen

Behaviour:
- Reset: FIFO empty and rd/wr pointers 0. rec_valid_o=0, rec_o=0, count_o=0, overflow_o=0, drop_cnt_o=0, retire_cnt_o=0. Async assert; deassert takes effect at the next edge.
- Record build, combinational from inputs:
  - seq = retire_cnt_o value before increment.
  - has_rd = (reg_addr_i!=0). rd_data is forced to 0 when !has_rd.
  - has_mem = (mem_addr_i!=0) | (mem_data_i!=0). A store of 0 to address 0 is unobservable and is recorded as has_mem=0 (documented limitation).
- Event at rising edge with update_i=1:
  - retire_cnt_o increments every time, including dropped events, wrapping mod 2^SEQ_W. Gaps in seq therefore expose drops.
  - Push when count_o<DEPTH, or when count_o==DEPTH and a pop happens in the same cycle.
  - Otherwise drop: overflow_o is set (sticky), drop_cnt_o increments and saturates at all-ones.
- Drain:
  - FWFT: rec_o presents the head entry whenever count_o>0; rec_valid_o = (count_o!=0).
  - Pop on rec_valid_o & rec_ready_i.
  - rec_o must hold stable while rec_valid_o & !rec_ready_i.
- Latency: a push into an empty FIFO gives rec_valid_o=1 with that record on the next cycle. No combinational path from update_i to rec_valid_o.
- Simultaneous push and pop:
  - Occupancy is unchanged.
  - When empty, only the push happens, since no pop is possible.
  - When full, the push is accepted.
- Pointers wrap mod DEPTH. count_o is held explicitly and ranges 0..DEPTH.
- clr_i overrides push, pop and all counters in the same cycle. The update_i of that cycle is discarded and not counted.
- rec_ready_i is ignored while rec_valid_o=0.
- Reset mid-drain discards all buffered records.

Optional Feature:
- Macro: RETIRE_TRACE_MEM_EN.
- Defined: retire_rec_t carries mem_addr, mem_data and has_mem as described.
- Undefined:
  - These fields are omitted from the record and the FIFO storage narrows.
  - mem_addr_i and mem_data_i stay as ports but are unused.
  - has_mem is absent.
- Everything else is identical in both builds.

Decomposition:
- riscv_pkg gains the retire_rec_t packed struct: seq, pc, instr, has_rd, rd_addr, rd_data, and the conditional mem fields.
- riscv_pkg also gains the TRACE_DEPTH_DEFAULT constant.
- Sub-module sync_fifo_fwft (WIDTH, DEPTH) holds storage, pointers and count.
- retire_trace_sink holds record packing, the push/drop decision, counters and the clear logic.

Test Plan:
- Basic order: 3 retires with pc=0x0,0x4,0x8, rec_ready_i=1 → 3 records in order with seq 0,1,2. rec_valid_o rises 1 cycle after the first update. count_o returns to 0.
- x0 normalization: reg_addr_i=0, reg_data_i=0xDEADBEEF → has_rd=0, rd_data=0. reg_addr_i=5, data 0x12 → has_rd=1, rd_data=0x12.
- Overflow: DEPTH=16, rec_ready_i=0, 20 retires → count_o=16, drop_cnt_o=4, overflow_o=1, retire_cnt_o=20. Drain yields seq 0..15.
- Full with concurrent pop: FIFO full, update_i=1 and rec_ready_i=1 in the same cycle → count_o stays 16, no drop, tail seq=16.
- Backpressure stability: rec_ready_i toggles 1-0-0-1 across 5 records → rec_o never changes while valid&!ready. All 5 records delivered once, in order.
- Clear/reset: 6 records buffered, then pulse clr_i together with update_i → next cycle count_o=0, retire_cnt_o=0, overflow_o=0. Async rst_i mid-drain zeros all outputs without waiting for a clock edge.
